sjr_method_arbiter: RTL and testbench

- Shares one Synthesijer-generated method port (`<m>_req` / `<m>_busy` / `<m>_return`) between N_REQ independent callers.
- Each caller sees its own req/busy/return triple with the same handshake as a direct method call.
- Sits between caller modules, or a bench, and a single callee instance such as a `test()` method.
- Calls are serialised round-robin, with a busy-rise timeout and a sticky error flag.

---
 rtl/sjr_method_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_sjr_method_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sjr_method_arbiter.sv
// sjr_method_arbiter
//   Shares one Synthesijer method port (_req/_busy/_return) between N_REQ
//   callers. Each caller keeps its own req/busy/return handshake, identical
//   to calling the method directly. Calls are served one at a time in
//   round-robin order; a callee that never raises busy is abandoned after
//   BUSY_TIMEOUT cycles and flagged on the sticky timeout_err.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req[N_REQ]          per-caller call request (rising edge starts a call)
//   busy[N_REQ]         per-caller busy, accept -> completion
//   ret[N_REQ*RET_W]    per-caller return, slice i at [i*RET_W +: RET_W]
//   m_req               to callee _req, one-cycle registered pulse
//   m_busy, m_return    from callee _busy / _return
//   grant_id            caller being served, 0 when idle
//   timeout_err         sticky busy-rise timeout flag

// Per-caller slot: edge detect, busy flag and held return value.
module sjr_arb_slot #(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             done,     // this caller's call finishes now
  input  logic             ld_ret,   // finish carries a valid return value
  input  logic [RET_W-1:0] m_return,
  output logic             busy,
  output logic [RET_W-1:0] ret
);
  logic             req_prev_q;
  logic             busy_q, busy_d;
  logic [RET_W-1:0] ret_q, ret_d;

  // Completion takes priority: busy_q is still 1 that cycle, so a
  // coincident rising edge is dropped by the ~busy_q term anyway.
  always_comb begin
    busy_d = busy_q;
    ret_d  = ret_q;
    if (done) begin
      busy_d = 1'b0;
      if (ld_ret) ret_d = m_return;
    end else if (req && !req_prev_q && !busy_q) begin
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_prev_q <= 1'b0;
      busy_q     <= 1'b0;
      ret_q      <= '0;
    end else begin
      req_prev_q <= req;
      busy_q     <= busy_d;
      ret_q      <= ret_d;
    end
  end

  assign busy = busy_q;
  assign ret  = ret_q;
endmodule

module sjr_method_arbiter #(
  parameter int N_REQ        = 4,
  parameter int RET_W        = 32,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  output logic [N_REQ-1:0]       busy,
  output logic [N_REQ*RET_W-1:0] ret,
  output logic                   m_req,
  input  logic                   m_busy,
  input  logic [RET_W-1:0]       m_return,
  output logic [2:0]             grant_id,
  output logic                   timeout_err
);
  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_ISSUE     = 2'd1;
  localparam logic [1:0]  S_WAIT_BUSY = 2'd2;
  localparam logic [1:0]  S_WAIT_DONE = 2'd3;
  localparam logic [15:0] TMO         = 16'(BUSY_TIMEOUT);
  localparam logic [2:0]  LAST        = 3'(N_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [15:0]      timer_q, timer_d;
  logic             m_req_q, m_req_d;
  logic             terr_q, terr_d;
  logic             cmpl, ld_ret;
  logic [N_REQ-1:0] pending, done;
  logic             pick_vld;
  logic [2:0]       pick_idx;
  logic [N_REQ-1:0] pend_rot;
  int               j;

  // A caller is pending from accept until completion, exactly the span
  // its busy bit is high, so busy doubles as the pending vector.
  assign pending = busy;

  // Round-robin pick: scan rr_ptr, rr_ptr+1, ... Scanning downwards so the
  // last hit written is the one closest to rr_ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    pend_rot = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      pend_rot = pending >> j;
      if (pend_rot[0]) begin
        pick_vld = 1'b1;
        pick_idx = 3'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    timer_d  = timer_q;
    m_req_d  = 1'b0;
    terr_d   = terr_q;
    cmpl     = 1'b0;
    ld_ret   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          m_req_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (m_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TMO) begin
          // Callee never answered: release the caller, keep its old ret.
          terr_d   = 1'b1;
          cmpl     = 1'b1;
          grant_d  = '0;
          rr_ptr_d = (grant_q == LAST) ? 3'd0 : grant_q + 3'd1;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin // S_WAIT_DONE, unbounded on purpose
        if (!m_busy) begin
          cmpl     = 1'b1;
          ld_ret   = 1'b1;
          grant_d  = '0;
          rr_ptr_d = (grant_q == LAST) ? 3'd0 : grant_q + 3'd1;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      m_req_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
      m_req_q  <= m_req_d;
      terr_q   <= terr_d;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    assign done[i] = cmpl & (grant_q == 3'(i));
    sjr_arb_slot #(.RET_W(RET_W)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .req      (req[i]),
      .done     (done[i]),
      .ld_ret   (ld_ret),
      .m_return (m_return),
      .busy     (busy[i]),
      .ret      (ret[i*RET_W +: RET_W])
    );
  end

  assign m_req       = m_req_q;
  assign grant_id    = grant_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_sjr_method_arbiter.sv
// Bench for sjr_method_arbiter: a callee model answers m_req pulses, a
// scoreboard queue holds {caller, return} in expected completion order and
// is popped on every busy falling edge.
module tb_sjr_method_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   busy;
  logic [N*W-1:0] ret;
  logic           m_req;
  logic           m_busy;
  logic [W-1:0]   m_return;
  logic [2:0]     grant_id;
  logic           timeout_err;

  always #5 clk = ~clk;

  sjr_method_arbiter #(.N_REQ(N), .RET_W(W), .BUSY_TIMEOUT(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .busy        (busy),
    .ret         (ret),
    .m_req       (m_req),
    .m_busy      (m_busy),
    .m_return    (m_return),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  // Callee: registers the m_req pulse, raises busy on the following edge,
  // holds it cur_l cycles, drives 0x100+L as busy falls.
  int          cur_l = 5;
  logic        ignore = 1'b0;
  logic        seen, cb_busy;
  logic [31:0] cb_ret;
  int          cnt;
  assign m_busy   = cb_busy;
  assign m_return = cb_ret;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      seen <= 1'b0; cb_busy <= 1'b0; cb_ret <= '0; cnt <= 0;
    end else begin
      seen <= m_req & ~ignore;
      if (seen) begin
        cb_busy <= 1'b1;
        cnt     <= cur_l - 1;
      end else if (cb_busy) begin
        if (cnt == 0) begin
          cb_busy <= 1'b0;
          cb_ret  <= 32'(32'h100 + cur_l);
        end else cnt <= cnt - 1;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  typedef struct { int id; logic [31:0] r; } exp_t;
  exp_t         sb[$];
  exp_t         e_mon;
  int           gq[$];
  int           mreq_cnt = 0;
  bit           mon_en = 0;
  logic [N-1:0] busy_prev = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_req) begin
        mreq_cnt++;
        gq.push_back(int'(grant_id));
      end
      for (int i = 0; i < N; i++) begin
        if (busy_prev[i] && !busy[i]) begin
          if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
          else begin
            e_mon = sb.pop_front();
            chk("sb_id", i, e_mon.id);
            chk("sb_ret", ret[i*W +: W], e_mon.r);
          end
        end
      end
    end
    busy_prev = busy;
  end

  task automatic wait_idle(input string tag, input int lim);
    bit ok;
    ok = 0;
    for (int c = 0; c < lim && !ok; c++) begin
      @(negedge clk); #1;
      if (busy == '0 && sb.size() == 0) ok = 1;
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int  bc, tg, tf, hc;
    bit  ok;
    // Held level: req[0] high from cycle 0 through reset.
    req[0] = 1'b1;
    cur_l  = 4;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_mreq", m_req, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_ret", |ret, 0);
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    mreq_cnt = 0;
    sb.push_back('{0, 32'h104});
    mon_en   = 1;
    repeat (1000) @(negedge clk);
    chk("held_mreq", mreq_cnt, 1);
    chk("held_sb", sb.size(), 0);
    req[0] = 1'b0;

    // Clean reset so the round-robin pointer restarts at 0.
    mon_en = 0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    @(negedge clk); mon_en = 1;

    // Contention: all four at once.
    cur_l = 3;
    gq.delete();
    @(negedge clk);
    req = '1;
    for (int i = 0; i < N; i++) sb.push_back('{i, 32'h103});
    wait_idle("cont_done", 200);
    chk("cont_ngrant", gq.size(), 4);
    for (int i = 0; i < N && i < gq.size(); i++) chk("cont_order", gq[i], i);
    req = '0;

    // Single call, L=5.
    cur_l = 5;
    repeat (2) @(negedge clk);
    mreq_cnt = 0;
    req[0]   = 1'b1;
    sb.push_back('{0, 32'h105});
    bc = 0;
    repeat (30) begin
      @(negedge clk); #1;
      if (busy[0]) bc++;
    end
    chk("single_busy_cyc", bc, 9);
    chk("single_mreq", mreq_cnt, 1);
    chk("single_terr", timeout_err, 0);
    chk("single_sb", sb.size(), 0);
    req[0] = 1'b0;

    // Fairness: 1 and 3 arrive while 2 is served; 3 must go first.
    cur_l = 6;
    gq.delete();
    @(negedge clk);
    req[2] = 1'b1;
    sb.push_back('{2, 32'h106});
    sb.push_back('{3, 32'h106});
    sb.push_back('{1, 32'h106});
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); #1;
      if (grant_id == 3'd2) ok = 1;
    end
    chk("fair_grant2", ok, 1);
    req[1] = 1'b1;
    req[3] = 1'b1;
    wait_idle("fair_done", 200);
    chk("fair_ngrant", gq.size(), 3);
    if (gq.size() >= 3) begin
      chk("fair_g0", gq[0], 2);
      chk("fair_g1", gq[1], 3);
      chk("fair_g2", gq[2], 1);
    end
    req = '0;

    // Timeout: callee ignores m_req; ret[1] keeps 0x106.
    ignore = 1'b1;
    @(negedge clk);
    req[1] = 1'b1;
    sb.push_back('{1, 32'h106});
    tg = -1; tf = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (m_req && tg < 0) tg = c;
      if (tg >= 0 && !busy[1] && tf < 0) tf = c;
    end
    chk("tmo_cycles", (tg >= 0 && tf >= 0) ? tf - tg : -1, 22);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_sb", sb.size(), 0);
    repeat (50) @(negedge clk);
    chk("tmo_sticky", timeout_err, 1);
    ignore = 1'b0;
    req[1] = 1'b0;

    // Reset in the middle of a long call.
    cur_l = 50;
    @(negedge clk);
    req[0] = 1'b1;
    ok = 0; hc = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk); #1;
      if (m_busy && busy[0]) hc++;
      if (hc >= 3) ok = 1;
    end
    chk("mid_reach", ok, 1);
    mon_en = 0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_mreq", m_req, 0);
    chk("mid_gid", grant_id, 0);
    chk("mid_terr", timeout_err, 0);
    chk("mid_ret", |ret, 0);
    req = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1;
    cur_l  = 7;
    @(negedge clk);
    req[2] = 1'b1;
    sb.push_back('{2, 32'h107});
    wait_idle("post_rst_done", 100);
    chk("post_rst_terr", timeout_err, 0);
    req[2] = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
